// File: rtl/nx_control_host_pkg.sv
// nx_control_host_pkg: shared Nexus control types, section width and helper for nx_control_host
package nx_control_host_pkg;
  localparam int TIMER_WIDTH              = 24;
  localparam int CONTROL_OUT_SECTION_BITS = 96;
  typedef enum logic [2:0] {
    CONTROL_REQ_TYPE_READ_PARAMS = 3'd0,
    CONTROL_REQ_TYPE_READ_STATUS = 3'd1,
    CONTROL_REQ_TYPE_SOFT_RESET  = 3'd2,
    CONTROL_REQ_TYPE_CONFIGURE   = 3'd3,
    CONTROL_REQ_TYPE_TRIGGER     = 3'd4,
    CONTROL_REQ_TYPE_TO_MESH     = 3'd5,
    CONTROL_REQ_TYPE_MEMORY      = 3'd6
  } control_req_type_t;
  typedef enum logic [2:0] {
    CONTROL_RESP_TYPE_PARAMS    = 3'd0,
    CONTROL_RESP_TYPE_STATUS    = 3'd1,
    CONTROL_RESP_TYPE_OUTPUTS   = 3'd2,
    CONTROL_RESP_TYPE_FROM_MESH = 3'd3,
    CONTROL_RESP_TYPE_PADDING   = 3'd7
  } control_resp_type_t;
  typedef struct packed {
    control_req_type_t command;
    logic [63:0]       payload;
  } control_request_t;
  typedef struct packed {
    control_resp_type_t format;
    logic [127:0]       payload;
  } control_response_t;
  typedef struct packed {
    logic [31:0] id;
    logic [15:0] version;
    logic [7:0]  rows;
    logic [7:0]  columns;
  } control_response_parameters_t;
  typedef struct packed {
    logic                   active;
    logic                   seen_low;
    logic                   first_tick;
    logic [4:0]             interval_set;
    logic [TIMER_WIDTH-1:0] cycle;
  } control_response_status_t;
  typedef struct packed {
    logic [TIMER_WIDTH-1:0]              stamp;
    logic [7:0]                          index;
    logic [CONTROL_OUT_SECTION_BITS-1:0] section;
  } control_response_outputs_t;
  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  column;
    logic [1:0]  command;
    logic [45:0] payload;
  } node_message_t;
  function automatic int num_sections(input int bits);
    return (bits + CONTROL_OUT_SECTION_BITS - 1) / CONTROL_OUT_SECTION_BITS;
  endfunction
endpackage

// File: rtl/nx_control_host_if.sv
// nx_control_host_if: host request, controller in/out, mesh and status signals of nx_control_host
// Signal names are from the host block's point of view (i_ = into nx_control_host, o_ = out of it).
// Modports: slave = nx_control_host, master = the host bridge / controller side driving it.
interface nx_control_host_if import nx_control_host_pkg::*; #(
  parameter int COLUMNS   = 3,
  parameter int OUTPUTS   = 32,
  parameter int MAX_READS = 4
) ();
  control_request_t                     i_req_data;
  logic                                 i_req_valid;
  logic                                 o_req_ready;
  control_request_t                     o_ctrl_in_data;
  logic                                 o_ctrl_in_valid;
  logic                                 i_ctrl_in_ready;
  control_response_t                    i_ctrl_out_data;
  logic                                 i_ctrl_out_valid;
  logic                                 o_ctrl_out_ready;
  control_response_parameters_t         o_params;
  logic                                 o_params_valid;
  control_response_status_t             o_status;
  logic                                 o_status_valid;
  node_message_t                        o_mesh_data;
  logic                                 o_mesh_valid;
  logic                                 i_mesh_ready;
  logic [COLUMNS*OUTPUTS-1:0]           o_outputs;
  logic [TIMER_WIDTH-1:0]               o_outputs_stamp;
  logic                                 o_outputs_valid;
  logic [$clog2(MAX_READS+1)-1:0]       o_pending;
  logic                                 o_err_sequence;
  logic                                 o_err_unexpected;
  modport slave (
    input  i_req_data, i_req_valid, i_ctrl_in_ready, i_ctrl_out_data, i_ctrl_out_valid, i_mesh_ready,
    output o_req_ready, o_ctrl_in_data, o_ctrl_in_valid, o_ctrl_out_ready, o_params, o_params_valid,
           o_status, o_status_valid, o_mesh_data, o_mesh_valid, o_outputs, o_outputs_stamp,
           o_outputs_valid, o_pending, o_err_sequence, o_err_unexpected
  );
  modport master (
    output i_req_data, i_req_valid, i_ctrl_in_ready, i_ctrl_out_data, i_ctrl_out_valid, i_mesh_ready,
    input  o_req_ready, o_ctrl_in_data, o_ctrl_in_valid, o_ctrl_out_ready, o_params, o_params_valid,
           o_status, o_status_valid, o_mesh_data, o_mesh_valid, o_outputs, o_outputs_stamp,
           o_outputs_valid, o_pending, o_err_sequence, o_err_unexpected
  );
endinterface

// File: rtl/nx_control_host_reassembly.sv
// nx_control_host_reassembly: collects 96-bit output sections into one mesh-output vector
// Ports: i_clk/i_rst (async active-high); i_clear soft-clears FSM and error; i_valid/i_section
//   deliver one OUTPUTS section; o_outputs/o_stamp/o_valid publish the vector; o_err_sequence sticky.
module nx_control_host_reassembly import nx_control_host_pkg::*; #(
  parameter int COLUMNS = 3,
  parameter int OUTPUTS = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_valid,
  input  control_response_outputs_t  i_section,
  output logic [COLUMNS*OUTPUTS-1:0] o_outputs,
  output logic [TIMER_WIDTH-1:0]     o_stamp,
  output logic                       o_valid,
  output logic                       o_err_sequence
);
  localparam int         NS   = num_sections(COLUMNS * OUTPUTS);
  localparam int         SB   = CONTROL_OUT_SECTION_BITS;
  localparam logic [7:0] LAST = 8'(NS - 1);
  typedef enum logic {ST_WAIT, ST_COLLECT} state_t;
  state_t                     r_state;
  logic [7:0]                 r_exp;
  logic [TIMER_WIDTH-1:0]     r_stamp;
  logic [NS*SB-1:0]           r_sects;
  logic [COLUMNS*OUTPUTS-1:0] r_outputs;
  logic [TIMER_WIDTH-1:0]     r_out_stamp;
  logic                       r_valid;
  logic                       r_err;
  logic [NS*SB-1:0]           w_sects;
  logic                       w_match;
  logic                       w_first;
  // Storage image with the incoming section dropped into its slot, so a publish sees it too.
  always_comb begin
    w_sects = r_sects;
    for (int s = 0; s < NS; s++)
      if (i_section.index == 8'(s)) w_sects[s*SB +: SB] = i_section.section;
  end
  assign w_match = r_state == ST_COLLECT && i_section.index == r_exp && i_section.stamp == r_stamp;
  assign w_first = i_section.index == 8'd0;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state     <= ST_WAIT;
      r_exp       <= '0;
      r_stamp     <= '0;
      r_sects     <= '0;
      r_outputs   <= '0;
      r_out_stamp <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else if (i_clear) begin
      r_state <= ST_WAIT;
      r_exp   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_valid) begin
        if (w_match) begin
          r_sects <= w_sects;
          if (r_exp == LAST) begin
            r_outputs   <= w_sects[COLUMNS*OUTPUTS-1:0];
            r_out_stamp <= i_section.stamp;
            r_valid     <= 1'b1;
            r_state     <= ST_WAIT;
          end else r_exp <= r_exp + 8'd1;
        end else if (w_first) begin
          // Section 0 always (re)starts a vector; arriving mid-collection is a sequence error.
          r_sects <= w_sects;
          r_stamp <= i_section.stamp;
          r_exp   <= 8'd1;
          if (r_state == ST_COLLECT) r_err <= 1'b1;
          if (NS == 1) begin
            r_outputs   <= w_sects[COLUMNS*OUTPUTS-1:0];
            r_out_stamp <= i_section.stamp;
            r_valid     <= 1'b1;
            r_state     <= ST_WAIT;
          end else r_state <= ST_COLLECT;
        end else begin
          r_err   <= 1'b1;
          r_state <= ST_WAIT;
        end
      end
    end
  assign o_outputs      = r_outputs;
  assign o_stamp        = r_out_stamp;
  assign o_valid        = r_valid;
  assign o_err_sequence = r_err;
endmodule

// File: rtl/nx_control_host.sv
// nx_control_host: host-side initiator for the Nexus control protocol
// Ports: i_clk, i_rst (async active-high); bus = nx_control_host_if.slave carrying the host request
//   stream, controller inbound/outbound streams, latched params/status, mesh message stream,
//   reassembled outputs with stamp, outstanding read count and sticky error flags.
// Optional: define NX_CONTROL_HOST_TIMEOUT_EN to add the read watchdog and the o_err_timeout port.
module nx_control_host import nx_control_host_pkg::*; #(
  parameter int COLUMNS        = 3,
  parameter int OUTPUTS        = 32,
  parameter int MAX_READS      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef NX_CONTROL_HOST_TIMEOUT_EN
  output logic o_err_timeout,
`endif
  nx_control_host_if.slave bus
);
  localparam int            PW    = $clog2(MAX_READS + 1);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_READS);
  control_request_t             r_in_data;
  logic                         r_in_valid;
  logic [PW-1:0]                r_pending;
  logic                         r_err_unexp;
  control_response_parameters_t r_params;
  control_response_status_t     r_status;
  logic                         r_params_valid;
  logic                         r_status_valid;
  node_message_t                r_fifo [2];
  logic                         r_wp;
  logic                         r_rp;
  logic [1:0]                   r_cnt;
  control_response_t            w_rsp;
  logic w_is_read, w_req_fire, w_soft, w_inc, w_rsp_fire, w_is_pr, w_dec, w_clr, w_push, w_pop;
  assign w_rsp      = bus.i_ctrl_out_data;
  assign w_is_read  = bus.i_req_data.command == CONTROL_REQ_TYPE_READ_PARAMS ||
                      bus.i_req_data.command == CONTROL_REQ_TYPE_READ_STATUS;
  // Reads are refused once MAX_READS are outstanding; other requests only need a free slot.
  assign bus.o_req_ready = (!r_in_valid || bus.i_ctrl_in_ready) && !(w_is_read && r_pending == MAX_P);
  assign w_req_fire = bus.i_req_valid && bus.o_req_ready;
  assign w_soft     = w_req_fire && bus.i_req_data.command == CONTROL_REQ_TYPE_SOFT_RESET;
  assign w_inc      = w_req_fire && w_is_read;
  assign bus.o_ctrl_out_ready = r_cnt != 2'd2;
  assign w_rsp_fire = bus.i_ctrl_out_valid && bus.o_ctrl_out_ready;
  assign w_is_pr    = w_rsp_fire && (w_rsp.format == CONTROL_RESP_TYPE_PARAMS ||
                                     w_rsp.format == CONTROL_RESP_TYPE_STATUS);
  assign w_dec      = w_is_pr && r_pending != '0;
  assign w_push     = w_rsp_fire && w_rsp.format == CONTROL_RESP_TYPE_FROM_MESH;
  assign w_pop      = r_cnt != 2'd0 && bus.i_mesh_ready;
`ifdef NX_CONTROL_HOST_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wd;
  logic          r_err_timeout;
  logic          w_to;
  assign w_to  = r_pending != '0 && r_wd == WW'(TIMEOUT_CYCLES - 1);
  assign w_clr = w_soft || w_to;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wd          <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wd <= (r_pending == '0 || w_to || w_is_pr || w_soft) ? '0 : r_wd + 1'b1;
      if (w_to) r_err_timeout <= 1'b1;
    end
  assign o_err_timeout = r_err_timeout;
`else
  assign w_clr = w_soft;
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_in_data   <= '0;
      r_in_valid  <= 1'b0;
      r_pending   <= '0;
      r_err_unexp <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_in_data  <= bus.i_req_data;
        r_in_valid <= 1'b1;
      end else if (bus.i_ctrl_in_ready) r_in_valid <= 1'b0;
      if (w_clr) r_pending <= '0;
      else if (w_inc && !w_dec) r_pending <= r_pending + 1'b1;
      else if (w_dec && !w_inc) r_pending <= r_pending - 1'b1;
      if (w_soft) r_err_unexp <= 1'b0;
      else if (w_is_pr && r_pending == '0) r_err_unexp <= 1'b1;
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_params       <= '0;
      r_status       <= '0;
      r_params_valid <= 1'b0;
      r_status_valid <= 1'b0;
      r_fifo[0]      <= '0;
      r_fifo[1]      <= '0;
      r_wp           <= 1'b0;
      r_rp           <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_params_valid <= w_rsp_fire && w_rsp.format == CONTROL_RESP_TYPE_PARAMS;
      r_status_valid <= w_rsp_fire && w_rsp.format == CONTROL_RESP_TYPE_STATUS;
      if (w_rsp_fire && w_rsp.format == CONTROL_RESP_TYPE_PARAMS)
        r_params <= control_response_parameters_t'(w_rsp.payload[$bits(control_response_parameters_t)-1:0]);
      if (w_rsp_fire && w_rsp.format == CONTROL_RESP_TYPE_STATUS)
        r_status <= control_response_status_t'(w_rsp.payload[$bits(control_response_status_t)-1:0]);
      if (w_push) begin
        r_fifo[r_wp] <= node_message_t'(w_rsp.payload[$bits(node_message_t)-1:0]);
        r_wp         <= !r_wp;
      end
      if (w_pop) r_rp <= !r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  nx_control_host_reassembly #(.COLUMNS(COLUMNS), .OUTPUTS(OUTPUTS)) u_reasm (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_clear        (w_soft),
    .i_valid        (w_rsp_fire && w_rsp.format == CONTROL_RESP_TYPE_OUTPUTS),
    .i_section      (control_response_outputs_t'(w_rsp.payload)),
    .o_outputs      (bus.o_outputs),
    .o_stamp        (bus.o_outputs_stamp),
    .o_valid        (bus.o_outputs_valid),
    .o_err_sequence (bus.o_err_sequence)
  );
  assign bus.o_ctrl_in_data   = r_in_data;
  assign bus.o_ctrl_in_valid  = r_in_valid;
  assign bus.o_params         = r_params;
  assign bus.o_params_valid   = r_params_valid;
  assign bus.o_status         = r_status;
  assign bus.o_status_valid   = r_status_valid;
  assign bus.o_mesh_data      = r_fifo[r_rp];
  assign bus.o_mesh_valid     = r_cnt != 2'd0;
  assign bus.o_pending        = r_pending;
  assign bus.o_err_unexpected = r_err_unexp;
endmodule

// File: tb/tb_nx_control_host.sv
// tb_nx_control_host: directed self-checking bench for nx_control_host (3- and 4-column builds)
module tb_nx_control_host;
  import nx_control_host_pkg::*;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  nx_control_host_if #(.COLUMNS(3), .OUTPUTS(32), .MAX_READS(4)) bus  ();
  nx_control_host_if #(.COLUMNS(4), .OUTPUTS(32), .MAX_READS(4)) bus4 ();
`ifdef NX_CONTROL_HOST_TIMEOUT_EN
  logic err_to;
  logic err_to4;
`endif
  nx_control_host #(.COLUMNS(3), .OUTPUTS(32), .MAX_READS(4)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
`ifdef NX_CONTROL_HOST_TIMEOUT_EN
    .o_err_timeout (err_to),
`endif
    .bus   (bus)
  );
  nx_control_host #(.COLUMNS(4), .OUTPUTS(32), .MAX_READS(4)) u_dut4 (
    .i_clk (clk),
    .i_rst (rst),
`ifdef NX_CONTROL_HOST_TIMEOUT_EN
    .o_err_timeout (err_to4),
`endif
    .bus   (bus4)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic control_request_t mk_req(input control_req_type_t c, input logic [63:0] p);
    return '{command: c, payload: p};
  endfunction
  function automatic control_response_t mk_rsp(input control_resp_type_t f, input logic [127:0] p);
    return '{format: f, payload: p};
  endfunction
  function automatic control_response_t mk_sec(input logic [7:0] idx, input logic [23:0] st,
                                               input logic [95:0] s);
    control_response_outputs_t o;
    o.stamp   = st;
    o.index   = idx;
    o.section = s;
    return '{format: CONTROL_RESP_TYPE_OUTPUTS, payload: o};
  endfunction
  logic [63:0] msgs [4];
  int k;
  int got;
  initial begin
    n_vec = 0;
    n_err = 0;
    msgs[0] = 64'h0102_0000_0000_00A0;
    msgs[1] = 64'h0304_0000_0000_00B1;
    msgs[2] = 64'h0506_0000_0000_00C2;
    msgs[3] = 64'h0708_0000_0000_00D3;
    rst = 1'b1;
    bus.i_req_data = '0;  bus.i_req_valid = 1'b0;  bus.i_ctrl_in_ready = 1'b1;
    bus.i_ctrl_out_data = '0;  bus.i_ctrl_out_valid = 1'b0;  bus.i_mesh_ready = 1'b1;
    bus4.i_req_data = '0; bus4.i_req_valid = 1'b0; bus4.i_ctrl_in_ready = 1'b1;
    bus4.i_ctrl_out_data = '0; bus4.i_ctrl_out_valid = 1'b0; bus4.i_mesh_ready = 1'b1;
    repeat (2) tick();
    check("rst_pending", bus.o_pending, 0);
    check("rst_in_valid", bus.o_ctrl_in_valid, 0);
    check("rst_flags", {bus.o_params_valid, bus.o_status_valid, bus.o_mesh_valid, bus.o_outputs_valid,
                        bus.o_err_sequence, bus.o_err_unexpected}, 0);
    check("rst_params", bus.o_params, 0);
    check("rst_outputs", bus.o_outputs, 0);
    check("rst_outputs4", bus4.o_outputs, 0);
    rst = 1'b0;
    tick();
    // READ_PARAMS, response five cycles later
    bus.i_req_data = mk_req(CONTROL_REQ_TYPE_READ_PARAMS, 64'h1);
    bus.i_req_valid = 1'b1;
    #1;
    check("rp_ready", bus.o_req_ready, 1);
    tick();
    bus.i_req_valid = 1'b0;
    check("rp_in_valid", bus.o_ctrl_in_valid, 1);
    check("rp_in_data", bus.o_ctrl_in_data, mk_req(CONTROL_REQ_TYPE_READ_PARAMS, 64'h1));
    check("rp_pending1", bus.o_pending, 1);
    repeat (4) tick();
    bus.i_ctrl_out_data = mk_rsp(CONTROL_RESP_TYPE_PARAMS, 128'h1122334455667788);
    bus.i_ctrl_out_valid = 1'b1;
    tick();
    bus.i_ctrl_out_valid = 1'b0;
    check("params", bus.o_params, 64'h1122334455667788);
    check("params_pulse", bus.o_params_valid, 1);
    check("rp_pending0", bus.o_pending, 0);
    tick();
    check("params_pulse_end", bus.o_params_valid, 0);
    check("params_hold", bus.o_params, 64'h1122334455667788);
    check("rp_in_empty", bus.o_ctrl_in_valid, 0);
    // slot holds while the controller stalls, then takes the next request at once
    bus.i_ctrl_in_ready = 1'b0;
    bus.i_req_data = mk_req(CONTROL_REQ_TYPE_CONFIGURE, 64'hAAAA);
    bus.i_req_valid = 1'b1;
    tick();
    bus.i_req_data = mk_req(CONTROL_REQ_TYPE_CONFIGURE, 64'hBBBB);
    #1;
    check("stall_ready", bus.o_req_ready, 0);
    tick();
    check("stall_data", bus.o_ctrl_in_data, mk_req(CONTROL_REQ_TYPE_CONFIGURE, 64'hAAAA));
    bus.i_ctrl_in_ready = 1'b1;
    #1;
    check("release_ready", bus.o_req_ready, 1);
    tick();
    bus.i_req_valid = 1'b0;
    check("next_data", bus.o_ctrl_in_data, mk_req(CONTROL_REQ_TYPE_CONFIGURE, 64'hBBBB));
    check("next_valid", bus.o_ctrl_in_valid, 1);
    tick();
    check("drained_valid", bus.o_ctrl_in_valid, 0);
    // asynchronous reset with a request stuck in the slot
    bus.i_ctrl_in_ready = 1'b0;
    bus.i_req_data = mk_req(CONTROL_REQ_TYPE_TRIGGER, 64'h5);
    bus.i_req_valid = 1'b1;
    tick();
    bus.i_req_valid = 1'b0;
    check("stuck_valid", bus.o_ctrl_in_valid, 1);
    rst = 1'b1;
    #1;
    check("async_rst_slot", bus.o_ctrl_in_valid, 0);
    rst = 1'b0;
    bus.i_ctrl_in_ready = 1'b1;
    tick();
    // credit limit: five READ_STATUS back-to-back, no responses
    for (int i = 0; i < 5; i++) begin
      bus.i_req_data = mk_req(CONTROL_REQ_TYPE_READ_STATUS, 64'(i));
      bus.i_req_valid = 1'b1;
      #1;
      check($sformatf("credit_ready%0d", i), bus.o_req_ready, (i < 4) ? 1 : 0);
      tick();
    end
    bus.i_req_valid = 1'b0;
    check("credit_pending", bus.o_pending, 4);
    bus.i_req_data = mk_req(CONTROL_REQ_TYPE_SOFT_RESET, 64'h0);
    bus.i_req_valid = 1'b1;
    tick();
    bus.i_req_valid = 1'b0;
    check("soft_pending", bus.o_pending, 0);
    // unexpected STATUS at pending 0
    bus.i_ctrl_out_data = mk_rsp(CONTROL_RESP_TYPE_STATUS, 128'hA0000042);
    bus.i_ctrl_out_valid = 1'b1;
    tick();
    bus.i_ctrl_out_valid = 1'b0;
    check("status", bus.o_status, 32'hA0000042);
    check("status_pulse", bus.o_status_valid, 1);
    check("unexp_set", bus.o_err_unexpected, 1);
    check("unexp_pending", bus.o_pending, 0);
    // simultaneous read accept and read response leave the count alone
    bus.i_req_data = mk_req(CONTROL_REQ_TYPE_READ_STATUS, 64'h0);
    bus.i_req_valid = 1'b1;
    tick();
    check("one_pending", bus.o_pending, 1);
    bus.i_req_data = mk_req(CONTROL_REQ_TYPE_READ_PARAMS, 64'h0);
    bus.i_ctrl_out_data = mk_rsp(CONTROL_RESP_TYPE_STATUS, 128'h12345678);
    bus.i_ctrl_out_valid = 1'b1;
    tick();
    bus.i_req_valid = 1'b0;
    bus.i_ctrl_out_valid = 1'b0;
    check("simul_pending", bus.o_pending, 1);
    check("unexp_sticky", bus.o_err_unexpected, 1);
    bus.i_req_data = mk_req(CONTROL_REQ_TYPE_SOFT_RESET, 64'h0);
    bus.i_req_valid = 1'b1;
    tick();
    bus.i_req_valid = 1'b0;
    check("soft_unexp", bus.o_err_unexpected, 0);
    check("soft_pending2", bus.o_pending, 0);
    check("soft_keep_status", bus.o_status, 32'h12345678);
    // unknown format is dropped
    bus.i_ctrl_out_data = mk_rsp(control_resp_type_t'(3'd5), 128'hFFFF);
    bus.i_ctrl_out_valid = 1'b1;
    tick();
    bus.i_ctrl_out_valid = 1'b0;
    check("drop_flags", {bus.o_mesh_valid, bus.o_params_valid, bus.o_status_valid, bus.o_outputs_valid,
                         bus.o_err_unexpected}, 0);
    // single-section vector (3 columns)
    bus.i_ctrl_out_data = mk_sec(8'd0, 24'd7, 96'hA5A5A5A5_0123456789ABCDEF);
    bus.i_ctrl_out_valid = 1'b1;
    tick();
    bus.i_ctrl_out_valid = 1'b0;
    check("one_outputs", bus.o_outputs, 96'hA5A5A5A5_0123456789ABCDEF);
    check("one_stamp", bus.o_outputs_stamp, 7);
    check("one_pulse", bus.o_outputs_valid, 1);
    tick();
    check("one_pulse_end", bus.o_outputs_valid, 0);
    bus.i_ctrl_out_data = mk_sec(8'd1, 24'd8, 96'h1);
    bus.i_ctrl_out_valid = 1'b1;
    tick();
    bus.i_ctrl_out_valid = 1'b0;
    check("one_bad_idx_err", bus.o_err_sequence, 1);
    check("one_bad_idx_keep", bus.o_outputs, 96'hA5A5A5A5_0123456789ABCDEF);
    // two-section vector (4 columns)
    bus4.i_ctrl_out_data = mk_sec(8'd0, 24'd3, 96'h0123456789ABCDEF00112233);
    bus4.i_ctrl_out_valid = 1'b1;
    tick();
    check("two_first_nopub", bus4.o_outputs_valid, 0);
    bus4.i_ctrl_out_data = mk_sec(8'd1, 24'd3, 96'hFFFFFFFFFFFFFFFFCAFEF00D);
    tick();
    bus4.i_ctrl_out_valid = 1'b0;
    check("two_outputs", bus4.o_outputs, 128'hCAFEF00D_0123456789ABCDEF00112233);
    check("two_stamp", bus4.o_outputs_stamp, 3);
    check("two_pulse", bus4.o_outputs_valid, 1);
    check("two_noerr", bus4.o_err_sequence, 0);
    bus4.i_ctrl_out_data = mk_sec(8'd1, 24'd3, 96'hBAD);
    bus4.i_ctrl_out_valid = 1'b1;
    tick();
    check("seq_err", bus4.o_err_sequence, 1);
    check("seq_nopub", bus4.o_outputs_valid, 0);
    bus4.i_ctrl_out_data = mk_sec(8'd0, 24'd3, 96'h111111112222222233333333);
    tick();
    check("seq_mid_nopub", bus4.o_outputs_valid, 0);
    bus4.i_ctrl_out_data = mk_sec(8'd1, 24'd3, 96'h44444444);
    tick();
    bus4.i_ctrl_out_valid = 1'b0;
    check("seq_outputs", bus4.o_outputs, 128'h44444444_111111112222222233333333);
    check("seq_pulse", bus4.o_outputs_valid, 1);
    bus4.i_ctrl_out_data = mk_sec(8'd0, 24'd5, 96'h9);
    bus4.i_ctrl_out_valid = 1'b1;
    tick();
    bus4.i_ctrl_out_data = mk_sec(8'd1, 24'd6, 96'h8);
    tick();
    bus4.i_ctrl_out_valid = 1'b0;
    check("stamp_nopub", bus4.o_outputs_valid, 0);
    check("stamp_keep", bus4.o_outputs, 128'h44444444_111111112222222233333333);
    bus4.i_req_data = mk_req(CONTROL_REQ_TYPE_SOFT_RESET, 64'h0);
    bus4.i_req_valid = 1'b1;
    tick();
    bus4.i_req_valid = 1'b0;
    check("soft_seq_clear", bus4.o_err_sequence, 0);
    // mesh FIFO fill with consumer stalled
    bus.i_mesh_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      bus.i_ctrl_out_data = mk_rsp(CONTROL_RESP_TYPE_FROM_MESH, {64'h0, msgs[k]});
      bus.i_ctrl_out_valid = 1'b1;
      #1;
      check($sformatf("mesh_fill_ready%0d", c), bus.o_ctrl_out_ready, (c < 2) ? 1 : 0);
      if (bus.o_ctrl_out_ready) k++;
      tick();
    end
    check("mesh_accepted", k, 2);
    check("mesh_head", bus.o_mesh_data, msgs[0]);
    bus.i_mesh_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (k < 4) bus.i_ctrl_out_data = mk_rsp(CONTROL_RESP_TYPE_FROM_MESH, {64'h0, msgs[k]});
      bus.i_ctrl_out_valid = k < 4;
      #1;
      if (bus.o_mesh_valid) begin
        check($sformatf("mesh_order%0d", got), bus.o_mesh_data, msgs[got]);
        got++;
      end
      if (k < 4 && bus.o_ctrl_out_ready) k++;
      tick();
    end
    bus.i_ctrl_out_valid = 1'b0;
    check("mesh_drained", got, 4);
    check("mesh_empty", bus.o_mesh_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/nx_control_host.md
Name: nx_control_host

Overview:
- Host-side initiator for the Nexus control protocol.
- Accepts host control requests, registers them onto the controller's inbound request stream, and tracks outstanding parameter/status reads.
- Decodes the outbound response stream: latches parameters and status, buffers forwarded mesh messages, and reassembles 96-bit output sections into one full mesh-output vector with its cycle stamp.
- Sits between a host bridge (UART/AXI) and the top-level controller.

Parameters:
COLUMNS, 3, mesh columns
OUTPUTS, 32, outputs per column
MAX_READS, 4, maximum outstanding READ_PARAMS + READ_STATUS requests
TIMEOUT_CYCLES, 1024, read watchdog limit (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_req_data  in  control_request_t  host request
i_req_valid  in  1  host request valid
o_req_ready  out  1  host request accepted
o_ctrl_in_data  out  control_request_t  request to controller
o_ctrl_in_valid  out  1  request valid
i_ctrl_in_ready  in  1  controller ready
i_ctrl_out_data  in  control_response_t  controller response
i_ctrl_out_valid  in  1  response valid
o_ctrl_out_ready  out  1  response accepted
o_params  out  control_response_parameters_t  last parameter response
o_params_valid  out  1  one-cycle pulse on update
o_status  out  control_response_status_t  last status response
o_status_valid  out  1  one-cycle pulse on update
o_mesh_data  out  node_message_t  forwarded mesh message
o_mesh_valid  out  1  mesh message valid
i_mesh_ready  in  1  mesh message consumer ready
o_outputs  out  COLUMNS*OUTPUTS  reassembled output vector
o_outputs_stamp  out  TIMER_WIDTH  cycle stamp of the vector
o_outputs_valid  out  1  one-cycle pulse when the vector is complete
o_pending  out  $clog2(MAX_READS+1)  outstanding read count
o_err_sequence  out  1  sticky: output section index out of order
o_err_unexpected  out  1  sticky: params/status response with no pending read

Behaviour:
- Reset: all outputs and all state are 0.
- Request slot:
  - One-entry register holds the outgoing request.
  - o_req_ready = (!o_ctrl_in_valid || i_ctrl_in_ready) && credit_ok.
  - credit_ok = 0 only when the request is READ_PARAMS/READ_STATUS and pending == MAX_READS.
  - Accepted request appears on o_ctrl_in_* the next cycle.
  - Data is held stable while valid && !ready.
  - Full throughput: one request per cycle.
- Pending counter:
  - +1 when a read request is accepted from the host.
  - -1 when a PARAMS or STATUS response is accepted.
  - Simultaneous +1/-1: counter unchanged.
  - A response at pending == 0 sets o_err_unexpected; the response is still latched and the counter stays 0.
- Soft reset: accepting a SOFT_RESET request clears the pending counter, the reassembly state and both error flags on the following cycle. Latched params/status are retained.
- Response acceptance: o_ctrl_out_ready = mesh buffer not full; it does not depend on response type. The accepted response is decoded by its format field:
  - PARAMS / STATUS: latched into o_params / o_status; matching valid pulses 1 cycle later.
  - FROM_MESH: pushed into a 2-entry mesh FIFO; the FIFO head drives o_mesh_*. Simultaneous push and pop when full is not possible because ready is low when full.
  - OUTPUTS: sent to reassembly.
  - Any other format: dropped silently.
- Reassembly FSM:
  - NUM_SECT = ceil(COLUMNS*OUTPUTS/96).
  - States: WAIT (expecting index 0) and COLLECT (expecting expected_idx).
  - WAIT, index 0: store section 0, capture stamp; go to COLLECT with expected_idx = 1. If NUM_SECT == 1, publish instead and stay in WAIT.
  - WAIT, index ≠ 0: set o_err_sequence, discard the section.
  - COLLECT, index == expected_idx and stamp matches: store the section. If it is the last section, publish and return to WAIT; otherwise expected_idx+1.
  - COLLECT, index 0: restart collection, set o_err_sequence.
  - COLLECT, any other mismatch (index or stamp): set o_err_sequence, go to WAIT.
  - Publish: o_outputs updated with the low COLLECTS*OUTPUTS bits of the assembled sections (padding dropped), o_outputs_stamp updated, o_outputs_valid pulses for 1 cycle. Outputs hold until the next publish.
- Reset mid-operation: asynchronous reset returns to WAIT with the request slot empty.

Optional Feature:
- NX_CONTROL_HOST_TIMEOUT_EN defined:
  - A watchdog counter runs while pending > 0 and resets on each read response.
  - Reaching TIMEOUT_CYCLES clears pending to 0 and raises a sticky o_err_timeout output port.
- Undefined: the port, the counter and this behaviour are absent.

Decomposition:
- The following come from the shared NXConstants package: control_request_t, control_response_t, response subtypes, the CONTROL_REQ_TYPE_* / CONTROL_RESP_TYPE_* enums, TIMER_WIDTH.
- Add a localparam-style constant CONTROL_OUT_SECTION_BITS = 96 to the package.
- Define the reassembly state enum locally.
- Sub-module nx_control_host_reassembly: the FSM plus section storage.

Test Plan:
- READ_PARAMS accepted, response returned 5 cycles later -> o_params latched, o_params_valid high exactly one cycle, o_pending 1 -> 0.
- Five READ_STATUS requests back-to-back with MAX_READS=4 and no responses -> 4 accepted, o_req_ready low on the 5th, o_pending = 4.
- COLUMNS=3, OUTPUTS=32 (96 bits, NUM_SECT=1): OUTPUTS response with index 0, stamp 7, section 0xA5.. -> o_outputs = section, o_outputs_stamp = 7, single pulse.
- COLUMNS=4 (NUM_SECT=2): indices 0, 1 with stamp 3 -> one publish of 128 bits. Indices 1, 0, 1 -> o_err_sequence set, then one publish.
- Four FROM_MESH responses while i_mesh_ready = 0 -> 2 buffered, o_ctrl_out_ready low. On release they drain in order with no loss.
- STATUS response with pending 0 -> o_err_unexpected set. SOFT_RESET request -> o_err_unexpected cleared, pending 0.
